execute_stage: RTL and testbench

//  RV32I execute stage: consumes ID/EX register outputs (*E), forwards operands, runs ALU, resolves branch/jump,

---
 rtl/execute_stage_if.sv | 58 +++++
 rtl/execute_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Bundle between the ID/EX register, the execute stage and the EX/MEM register.
// The upstream side (ID/EX register and hazard unit) uses the master modport.
// The execute stage uses the slave modport.
// Handshake: no valid/ready pair. The stage asserts o_busy while a multicycle
// shift runs. While o_busy is high the master holds every *E field and the
// forwarding selects stable. The stage loads a bubble into EX/MEM on each of
// those cycles. A low o_busy means the EX/MEM register captures this cycle.
interface execute_stage_if #(
  parameter int XLEN = 32
);
  // ID/EX register outputs
  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic            JalrE;
  logic [2:0]      BranchFunct3E;
  logic [3:0]      ALUControlE;
  logic            ALUSrcE;
  logic [XLEN-1:0] Rd1E;
  logic [XLEN-1:0] Rd2E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] ExtImmE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RdE;
  // forwarding controls and the writeback value
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;
  // redirect toward fetch
  logic [XLEN-1:0] PCTargetE;
  logic            PCSrcE;
  // EX/MEM register outputs
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, JalrE,
           BranchFunct3E, ALUControlE, ALUSrcE, Rd1E, Rd2E, PCE, ExtImmE,
           PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
    input  PCTargetE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, JalrE,
           BranchFunct3E, ALUControlE, ALUSrcE, Rd1E, Rd2E, PCE, ExtImmE,
           PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
    output PCTargetE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage.
// It forwards operands, runs the ALU and resolves branch and jump targets.
// Results are registered into EX/MEM.
// Shifts with a nonzero amount go through a 1-bit/cycle shifter.
// The stage stalls upstream until that shifter finishes.
module execute_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_flush,
  execute_stage_if.slave ex,
  output logic          o_busy,
  output logic          o_dbg_state
);

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLT   = 4'h5;
  localparam logic [3:0] ALU_SLTU  = 4'h6;
  localparam logic [3:0] ALU_SLL   = 4'h7;
  localparam logic [3:0] ALU_SRL   = 4'h8;
  localparam logic [3:0] ALU_SRA   = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  logic [XLEN-1:0]      r_acc;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [1:0]           r_sh_op;
  logic                 r_sh_regwrite;
  logic [1:0]           r_sh_resultsrc;
  logic [4:0]           r_sh_rd;
  logic [XLEN-1:0]      r_sh_pcplus4;

  logic [XLEN-1:0]      w_src_a;
  logic [XLEN-1:0]      w_write_data;
  logic [XLEN-1:0]      w_src_b;
  logic [SHAMT_W-1:0]   w_shamt;
  logic                 w_is_shift;
  logic                 w_start_shift;
  logic [1:0]           w_sh_op;
  logic [XLEN-1:0]      w_alu_result;
  logic                 w_lt_s;
  logic                 w_lt_u;
  logic                 w_br_eq;
  logic                 w_br_lt_s;
  logic                 w_br_lt_u;
  logic                 w_taken;
  logic [XLEN-1:0]      w_jalr_sum;
  logic [XLEN-1:0]      w_acc_next;

  // Operand A mux: a select of 11 behaves like 00 (register file).
  always_comb begin
    w_src_a = ex.Rd1E;
    case (ex.ForwardAE)
      2'b10:   w_src_a = ex.ALUResultM;
      2'b01:   w_src_a = ex.ResultW;
      default: w_src_a = ex.Rd1E;
    endcase
  end

  // Store-data mux. Its output is also operand B when ALUSrcE is 0.
  always_comb begin
    w_write_data = ex.Rd2E;
    case (ex.ForwardBE)
      2'b10:   w_write_data = ex.ALUResultM;
      2'b01:   w_write_data = ex.ResultW;
      default: w_write_data = ex.Rd2E;
    endcase
  end

  assign w_src_b    = ex.ALUSrcE ? ex.ExtImmE : w_write_data;
  assign w_shamt    = w_src_b[SHAMT_W-1:0];
  assign w_is_shift = (ex.ALUControlE == ALU_SLL) || (ex.ALUControlE == ALU_SRL) ||
                      (ex.ALUControlE == ALU_SRA);
  assign w_start_shift = (r_state == ST_IDLE) && w_is_shift && (w_shamt != '0);

  // Stall stays high for the whole shift, including the cycle the shift is presented.
  assign o_busy      = w_start_shift || ((r_state == ST_SHIFT) && (r_cnt != '0));
  assign o_dbg_state = r_state;

  assign w_lt_s = $signed(w_src_a) < $signed(w_src_b);
  assign w_lt_u = w_src_a < w_src_b;

  // Single-cycle ALU. A shift reaches this path only with a zero amount, so it passes SrcA through.
  always_comb begin
    w_alu_result = '0;
    case (ex.ALUControlE)
      ALU_ADD:   w_alu_result = w_src_a + w_src_b;
      ALU_SUB:   w_alu_result = w_src_a - w_src_b;
      ALU_AND:   w_alu_result = w_src_a & w_src_b;
      ALU_OR:    w_alu_result = w_src_a | w_src_b;
      ALU_XOR:   w_alu_result = w_src_a ^ w_src_b;
      ALU_SLT:   w_alu_result = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU:  w_alu_result = {{(XLEN-1){1'b0}}, w_lt_u};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   w_alu_result = w_src_a;
      ALU_PASSB: w_alu_result = w_src_b;
      default:   w_alu_result = '0;
    endcase
  end

  assign w_br_eq   = (w_src_a == w_write_data);
  assign w_br_lt_s = $signed(w_src_a) < $signed(w_write_data);
  assign w_br_lt_u = w_src_a < w_write_data;

  // Branch condition. It always compares register operands, never the immediate.
  always_comb begin
    w_taken = 1'b0;
    case (ex.BranchFunct3E)
      3'b000:  w_taken = w_br_eq;
      3'b001:  w_taken = !w_br_eq;
      3'b100:  w_taken = w_br_lt_s;
      3'b101:  w_taken = !w_br_lt_s;
      3'b110:  w_taken = w_br_lt_u;
      3'b111:  w_taken = !w_br_lt_u;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_jalr_sum   = w_src_a + ex.ExtImmE;
  assign ex.PCTargetE = ex.JalrE ? {w_jalr_sum[XLEN-1:1], 1'b0} : (ex.PCE + ex.ExtImmE);
  // No redirect while stalled: the instruction in EX has not completed yet.
  assign ex.PCSrcE    = !o_busy && (ex.JumpE || (ex.BranchE && w_taken));

  // Map the ALU opcode onto the shifter's own direction code.
  always_comb begin
    w_sh_op = SH_SLL;
    case (ex.ALUControlE)
      ALU_SRL: w_sh_op = SH_SRL;
      ALU_SRA: w_sh_op = SH_SRA;
      default: w_sh_op = SH_SLL;
    endcase
  end

  // One-bit step of the iterative shifter. SRA refills from the sign bit.
  always_comb begin
    w_acc_next = r_acc;
    case (r_sh_op)
      SH_SLL:  w_acc_next = {r_acc[XLEN-2:0], 1'b0};
      SH_SRL:  w_acc_next = {1'b0, r_acc[XLEN-1:1]};
      SH_SRA:  w_acc_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
      default: w_acc_next = r_acc;
    endcase
  end

  // Shift FSM.
  // Operands and control are latched on entry, so forwarding changes during the shift have no effect.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_sh_op        <= SH_SLL;
      r_sh_regwrite  <= 1'b0;
      r_sh_resultsrc <= 2'b00;
      r_sh_rd        <= 5'd0;
      r_sh_pcplus4   <= '0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_shift) begin
            r_acc          <= w_src_a;
            r_cnt          <= w_shamt;
            r_sh_op        <= w_sh_op;
            r_sh_regwrite  <= ex.RegWriteE;
            r_sh_resultsrc <= ex.ResultSrcE;
            r_sh_rd        <= ex.RdE;
            r_sh_pcplus4   <= ex.PCPlus4E;
            r_state        <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - SHAMT_W'(1);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // EX/MEM register: a bubble on flush or stall, the shifter result when a shift completes, otherwise the ALU result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ex.RegWriteM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
      ex.ResultSrcM <= 2'b00;
      ex.RdM        <= 5'd0;
      ex.ALUResultM <= '0;
      ex.WriteDataM <= '0;
      ex.PCPlus4M   <= '0;
    end else if (i_flush || o_busy) begin
      ex.RegWriteM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
      ex.ResultSrcM <= 2'b00;
      ex.RdM        <= 5'd0;
      ex.ALUResultM <= '0;
      ex.WriteDataM <= '0;
      ex.PCPlus4M   <= '0;
    end else if (r_state == ST_SHIFT) begin
      ex.RegWriteM  <= r_sh_regwrite;
      ex.MemWriteM  <= 1'b0;
      ex.ResultSrcM <= r_sh_resultsrc;
      ex.RdM        <= r_sh_rd;
      ex.ALUResultM <= r_acc;
      ex.WriteDataM <= '0;
      ex.PCPlus4M   <= r_sh_pcplus4;
    end else begin
      ex.RegWriteM  <= ex.RegWriteE;
      ex.MemWriteM  <= ex.MemWriteE && !w_is_shift;
      ex.ResultSrcM <= ex.ResultSrcE;
      ex.RdM        <= ex.RdE;
      ex.ALUResultM <= w_alu_result;
      ex.WriteDataM <= w_write_data;
      ex.PCPlus4M   <= ex.PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases from the stage's behaviour list, then randomized instructions checked against an arithmetic reference model.
module tb_execute_stage;
  localparam int XLEN = 32;

  logic i_clk = 1'b0;
  logic i_rstn;
  logic i_flush;
  logic o_busy;
  logic o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int last_busy_cnt = 0;

  // expected ALUResultM values, oldest first
  logic [XLEN-1:0] exp_q[$];
  // value the model believes is on ALUResultM (source for ForwardX = 10)
  logic [XLEN-1:0] m_alu_m = '0;

  execute_stage_if #(.XLEN(XLEN)) bus ();

  execute_stage #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_flush     (i_flush),
    .ex          (bus.slave),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // clock / watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_fwd(input logic [31:0] rf, input logic [1:0] sel,
                                          input logic [31:0] alu_m, input logic [31:0] res_w);
    if (sel == 2'b10) return alu_m;
    if (sel == 2'b01) return res_w;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h6: return (a < b) ? 32'd1 : 32'd0;
      4'h7: return a << sh;
      4'h8: return a >> sh;
      4'h9: return $signed(a) >>> sh;
      4'hA: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic nop_inputs();
    bus.RegWriteE     = 1'b0;
    bus.ResultSrcE    = 2'b00;
    bus.MemWriteE     = 1'b0;
    bus.JumpE         = 1'b0;
    bus.BranchE       = 1'b0;
    bus.JalrE         = 1'b0;
    bus.BranchFunct3E = 3'b000;
    bus.ALUControlE   = 4'h0;
    bus.ALUSrcE       = 1'b0;
    bus.Rd1E          = '0;
    bus.Rd2E          = '0;
    bus.PCE           = '0;
    bus.ExtImmE       = '0;
    bus.PCPlus4E      = '0;
    bus.RdE           = 5'd0;
    bus.ForwardAE     = 2'b00;
    bus.ForwardBE     = 2'b00;
    bus.ResultW       = '0;
  endtask

  // Called 1 time unit after a rising edge with the instruction already driven.
  // Checks the redirect, the stall length and the bubbles, then the EX/MEM contents after capture.
  task automatic exec_op(input string tag);
    logic [31:0] a, wd, b, res, tgt, pc4;
    logic        sh, exp_pcsrc, rw, mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    int          exp_busy, busy_cnt;
    a   = ref_fwd(bus.Rd1E, bus.ForwardAE, m_alu_m, bus.ResultW);
    wd  = ref_fwd(bus.Rd2E, bus.ForwardBE, m_alu_m, bus.ResultW);
    b   = bus.ALUSrcE ? bus.ExtImmE : wd;
    sh  = (bus.ALUControlE >= 4'h7) && (bus.ALUControlE <= 4'h9);
    exp_busy = (sh && (b[4:0] != 5'd0)) ? (int'(b[4:0]) + 1) : 0;
    res = ref_alu(bus.ALUControlE, a, b);
    tgt = bus.JalrE ? ((a + bus.ExtImmE) & ~32'h1) : (bus.PCE + bus.ExtImmE);
    exp_pcsrc = (exp_busy == 0) && (bus.JumpE || (bus.BranchE && ref_taken(bus.BranchFunct3E, a, wd)));
    rw  = bus.RegWriteE;
    mw  = bus.MemWriteE && !sh;
    rs  = bus.ResultSrcE;
    rd  = bus.RdE;
    pc4 = bus.PCPlus4E;
    exp_q.push_back(res);
    #1;
    check($sformatf("%s.pctarget", tag), bus.PCTargetE, tgt);
    check($sformatf("%s.pcsrc", tag), 32'(bus.PCSrcE), 32'(exp_pcsrc));
    check($sformatf("%s.busy0", tag), 32'(o_busy), 32'(exp_busy != 0));
    busy_cnt = 0;
    while (o_busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      @(posedge i_clk); #1;
      // the shifter latched its operand, so a new writeback value must not matter
      bus.ResultW = $urandom();
      check($sformatf("%s.bubble_rw", tag), 32'(bus.RegWriteM), 32'd0);
      check($sformatf("%s.bubble_mw", tag), 32'(bus.MemWriteM), 32'd0);
    end
    last_busy_cnt = busy_cnt;
    check($sformatf("%s.busy_cycles", tag), 32'(busy_cnt), 32'(exp_busy));
    @(posedge i_clk); #1;
    res = exp_q.pop_front();
    check($sformatf("%s.alu_m", tag), bus.ALUResultM, res);
    check($sformatf("%s.regwrite_m", tag), 32'(bus.RegWriteM), 32'(rw));
    check($sformatf("%s.memwrite_m", tag), 32'(bus.MemWriteM), 32'(mw));
    check($sformatf("%s.resultsrc_m", tag), 32'(bus.ResultSrcM), 32'(rs));
    check($sformatf("%s.rd_m", tag), 32'(bus.RdM), 32'(rd));
    check($sformatf("%s.pcplus4_m", tag), bus.PCPlus4M, pc4);
    if (!sh) check($sformatf("%s.wdata_m", tag), bus.WriteDataM, wd);
    m_alu_m = res;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rstn  = 1'b0;
    i_flush = 1'b0;
    nop_inputs();

    // reset state
    #12;
    check("rst.alu_m", bus.ALUResultM, 32'd0);
    check("rst.regwrite_m", 32'(bus.RegWriteM), 32'd0);
    check("rst.pcplus4_m", bus.PCPlus4M, 32'd0);
    check("rst.rd_m", 32'(bus.RdM), 32'd0);
    check("rst.busy", 32'(o_busy), 32'd0);
    check("rst.state", 32'(o_dbg_state), 32'd0);
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // ADD wraps around
    bus.Rd1E = 32'hFFFF_FFFF; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd1;
    bus.RegWriteE = 1'b1; bus.RdE = 5'd5;
    exec_op("add_wrap");
    check("add_wrap.const_alu", bus.ALUResultM, 32'd0);
    check("add_wrap.const_rd", 32'(bus.RdM), 32'd5);

    // SLL by 5: six stall cycles, result written once
    nop_inputs();
    bus.ALUControlE = 4'h7; bus.Rd1E = 32'd1; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd5;
    bus.RegWriteE = 1'b1; bus.RdE = 5'd9; bus.PCPlus4E = 32'h44; bus.MemWriteE = 1'b1;
    exec_op("sll5");
    check("sll5.const_busy", 32'(last_busy_cnt), 32'd6);
    check("sll5.const_alu", bus.ALUResultM, 32'h20);
    nop_inputs();
    @(posedge i_clk); #1;
    check("sll5.one_cycle", 32'(bus.RegWriteM), 32'd0);
    m_alu_m = 32'd0;

    // SRA and SRL by 31
    nop_inputs();
    bus.ALUControlE = 4'h9; bus.Rd1E = 32'h8000_0000; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd31;
    bus.RegWriteE = 1'b1; bus.RdE = 5'd3;
    exec_op("sra31");
    check("sra31.const_alu", bus.ALUResultM, 32'hFFFF_FFFF);
    bus.ALUControlE = 4'h8;
    exec_op("srl31");
    check("srl31.const_alu", bus.ALUResultM, 32'h0000_0001);

    // BLT/BLTU with operand A forwarded from ALUResultM = -3
    nop_inputs();
    bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'hFFFF_FFFD;
    exec_op("mk_neg3");
    nop_inputs();
    bus.ForwardAE = 2'b10; bus.Rd2E = 32'd2; bus.BranchE = 1'b1; bus.BranchFunct3E = 3'b100;
    bus.PCE = 32'h100; bus.ExtImmE = 32'h20; bus.ALUControlE = 4'h1;
    #1;
    check("blt.const_pcsrc", 32'(bus.PCSrcE), 32'd1);
    check("blt.const_target", bus.PCTargetE, 32'h120);
    bus.BranchFunct3E = 3'b110;
    #1;
    check("bltu.const_pcsrc", 32'(bus.PCSrcE), 32'd0);
    bus.BranchFunct3E = 3'b100;
    exec_op("blt");

    // JALR clears bit 0 of the target
    nop_inputs();
    bus.Rd1E = 32'h1003; bus.ExtImmE = 32'd4; bus.ALUSrcE = 1'b1; bus.JalrE = 1'b1; bus.JumpE = 1'b1;
    bus.PCPlus4E = 32'h208; bus.RegWriteE = 1'b1; bus.ResultSrcE = 2'b10; bus.RdE = 5'd1;
    #1;
    check("jalr.const_target", bus.PCTargetE, 32'h1006);
    check("jalr.const_pcsrc", 32'(bus.PCSrcE), 32'd1);
    exec_op("jalr");
    check("jalr.const_pc4", bus.PCPlus4M, 32'h208);

    // flush on the third stall cycle of SRL by 10
    nop_inputs();
    bus.ALUControlE = 4'h8; bus.Rd1E = 32'hF000_0000; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd10;
    bus.RegWriteE = 1'b1; bus.RdE = 5'd7;
    #1;
    check("flush.busy_c1", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_flush = 1'b1;
    #1;
    check("flush.busy_c3", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    nop_inputs();
    #1;
    check("flush.busy_after", 32'(o_busy), 32'd0);
    check("flush.state_after", 32'(o_dbg_state), 32'd0);
    check("flush.regwrite_after", 32'(bus.RegWriteM), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk); #1;
      check("flush.no_late_write", 32'(bus.RegWriteM), 32'd0);
    end
    m_alu_m = 32'd0;

    // flush discards an instruction presented in the same cycle
    bus.Rd1E = 32'd5; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd7; bus.RegWriteE = 1'b1; bus.RdE = 5'd4;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    check("flush_new.regwrite", 32'(bus.RegWriteM), 32'd0);
    check("flush_new.alu", bus.ALUResultM, 32'd0);
    nop_inputs();
    @(posedge i_clk); #1;
    m_alu_m = 32'd0;

    // async reset clears EX/MEM without a clock edge
    bus.Rd1E = 32'd40; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd2; bus.RegWriteE = 1'b1; bus.RdE = 5'd12;
    exec_op("pre_rst");
    nop_inputs();
    #2 i_rstn = 1'b0;
    #1;
    check("arst.regwrite", 32'(bus.RegWriteM), 32'd0);
    check("arst.alu", bus.ALUResultM, 32'd0);
    check("arst.rd", 32'(bus.RdM), 32'd0);
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;
    m_alu_m = 32'd0;

    // async reset in the middle of a shift
    bus.ALUControlE = 4'h7; bus.Rd1E = 32'h3; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd20; bus.RegWriteE = 1'b1;
    repeat (4) @(posedge i_clk);
    #2 i_rstn = 1'b0;
    nop_inputs();
    #1;
    check("arst_shift.state", 32'(o_dbg_state), 32'd0);
    check("arst_shift.busy", 32'(o_busy), 32'd0);
    check("arst_shift.regwrite", 32'(bus.RegWriteM), 32'd0);
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;
    m_alu_m = 32'd0;
    bus.Rd1E = 32'd100; bus.Rd2E = 32'd58; bus.ALUControlE = 4'h1; bus.RegWriteE = 1'b1; bus.RdE = 5'd2;
    exec_op("post_rst_sub");

    // randomized instructions
    for (int n = 0; n < 60; n++) begin
      nop_inputs();
      bus.ALUControlE   = 4'($urandom_range(0, 11));
      bus.ALUSrcE       = 1'($urandom_range(0, 1));
      bus.Rd1E          = $urandom();
      bus.Rd2E          = $urandom();
      bus.ExtImmE       = $urandom();
      bus.PCE           = $urandom();
      bus.PCPlus4E      = $urandom();
      bus.ResultW       = $urandom();
      bus.ForwardAE     = 2'($urandom_range(0, 3));
      bus.ForwardBE     = 2'($urandom_range(0, 3));
      bus.RegWriteE     = 1'($urandom_range(0, 1));
      bus.MemWriteE     = 1'($urandom_range(0, 1));
      bus.ResultSrcE    = 2'($urandom_range(0, 3));
      bus.RdE           = 5'($urandom_range(0, 31));
      bus.BranchE       = 1'($urandom_range(0, 1));
      bus.BranchFunct3E = 3'($urandom_range(0, 7));
      bus.JumpE         = ($urandom_range(0, 3) == 0);
      bus.JalrE         = 1'($urandom_range(0, 1));
      exec_op($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
